// File: rtl/unnamed_adc_scanner.sv
// Round-robin scanner for an 8-channel SPI ADC with CONVST/SCK/SDI/SDO framing.
// Samples are tagged with the channel programmed one frame earlier.
module unnamed_adc_scanner #(
    parameter int SCK_DIV = 2,
    parameter int T_CONV  = 80
) (
    input  logic        adc_clk,
    input  logic        adc_reset,
    input  logic        enable,
    input  logic [7:0]  chan_mask,
    input  logic        unipolar,
    output logic        CONVST,
    output logic        SCK,
    output logic        SDI,
    input  logic        SDO,
    output logic [12:0] streaming_source_data,
    output logic [2:0]  streaming_source_channel,
    output logic        streaming_source_valid,
    output logic        busy
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_CONV    = 2'd1;
    localparam logic [1:0]  S_SHIFT   = 2'd2;
    localparam logic [1:0]  S_DONE    = 2'd3;
    localparam logic [15:0] CONV_LAST = 16'(T_CONV - 1);
    localparam logic [7:0]  DIV_LAST  = 8'(SCK_DIV - 1);
    localparam logic [4:0]  HALF_LAST = 5'd23;

    function automatic logic [2:0] lowest_ch(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            r = m[i] ? 3'(i) : r;
        end
        return r;
    endfunction

    // Nearest set bit above cur, wrapping 7->0; cur itself if it is the only one.
    function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [7:0] m);
        logic [2:0] r;
        logic [2:0] cand;
        r = cur;
        for (int i = 7; i >= 1; i--) begin
            cand = cur + 3'(i);
            r    = m[cand] ? cand : r;
        end
        return r;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  half_q, half_d;
    logic [11:0] shreg_q, shreg_d;
    logic [2:0]  prog_q, prog_d;
    logic [2:0]  tag_q, tag_d;
    logic [2:0]  low_q, low_d;
    logic        dummy_q, dummy_d;

    logic        convst_q, convst_d;
    logic        sck_q, sck_d;
    logic        sdi_q, sdi_d;
    logic [12:0] data_q, data_d;
    logic [2:0]  chan_q, chan_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;

    logic        start_ok_s;
    logic        emit_s;
    logic [3:0]  period_s;
    logic [5:0]  cfg_s;

    // Frame sequencing: state, phase counters, sample shift register, channel bookkeeping.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        half_d     = half_q;
        shreg_d    = shreg_q;
        prog_d     = prog_q;
        tag_d      = tag_q;
        low_d      = low_q;
        dummy_d    = dummy_q;
        start_ok_s = enable && (chan_mask != 8'd0);

        case (state_q)
            S_IDLE: begin
                if (start_ok_s) begin
                    state_d = S_CONV;
                    cnt_d   = 16'd0;
                    prog_d  = lowest_ch(chan_mask);
                    low_d   = lowest_ch(chan_mask);
                    dummy_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CONV: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = S_SHIFT;
                    div_d   = 8'd0;
                    half_d  = 5'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SHIFT: begin
                // SDO is captured at the end of the first cycle of each SCK-high phase.
                if (half_q[0] && (div_q == 8'd0)) begin
                    shreg_d = {shreg_q[10:0], SDO};
                end else begin
                    shreg_d = shreg_q;
                end
                if (div_q == DIV_LAST) begin
                    div_d = 8'd0;
                    if (half_q == HALF_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        half_d = half_q + 5'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            S_DONE: begin
                if (start_ok_s) begin
                    state_d = S_CONV;
                    cnt_d   = 16'd0;
                    tag_d   = prog_q;
                    prog_d  = next_ch(prog_q, chan_mask);
                    low_d   = lowest_ch(chan_mask);
                    dummy_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                    dummy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                dummy_d = 1'b1;
            end
        endcase
    end

    // Registered-output next values, derived from the upcoming state and counters.
    always_comb begin
        period_s = half_d[4:1];
        cfg_s    = {1'b1, prog_q[0], prog_q[2], prog_q[1], unipolar, 1'b0};
        emit_s   = (state_d == S_DONE) && !dummy_q;
        convst_d = (state_d == S_CONV) && (cnt_d < 16'd2);
        sck_d    = (state_d == S_SHIFT) && half_d[0];
        busy_d   = (state_d != S_IDLE);
        if ((state_d == S_SHIFT) && (period_s < 4'd6)) begin
            sdi_d = cfg_s[3'd5 - period_s[2:0]];
        end else begin
            sdi_d = 1'b0;
        end
        if (emit_s) begin
            valid_d = 1'b1;
            data_d  = {(tag_q == low_q), shreg_d};
            chan_d  = tag_q;
        end else begin
            valid_d = 1'b0;
            data_d  = data_q;
            chan_d  = chan_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge adc_clk) begin
        if (adc_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            div_q    <= 8'd0;
            half_q   <= 5'd0;
            shreg_q  <= 12'd0;
            prog_q   <= 3'd0;
            tag_q    <= 3'd0;
            low_q    <= 3'd0;
            dummy_q  <= 1'b1;
            convst_q <= 1'b0;
            sck_q    <= 1'b0;
            sdi_q    <= 1'b0;
            data_q   <= 13'd0;
            chan_q   <= 3'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            half_q   <= half_d;
            shreg_q  <= shreg_d;
            prog_q   <= prog_d;
            tag_q    <= tag_d;
            low_q    <= low_d;
            dummy_q  <= dummy_d;
            convst_q <= convst_d;
            sck_q    <= sck_d;
            sdi_q    <= sdi_d;
            data_q   <= data_d;
            chan_q   <= chan_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign CONVST                   = convst_q;
    assign SCK                      = sck_q;
    assign SDI                      = sdi_q;
    assign streaming_source_data    = data_q;
    assign streaming_source_channel = chan_q;
    assign streaming_source_valid   = valid_q;
    assign busy                     = busy_q;

endmodule

// File: tb/tb_unnamed_adc_scanner.sv
// Randomized bench for unnamed_adc_scanner: an ADC model decodes SDI words and
// returns per-channel values; a frame-level model predicts the emitted stream.
module tb_unnamed_adc_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst, en, uni, sdo;
    logic [7:0]  mask;
    logic        convst, sck, sdi, valid, busy;
    logic [12:0] data;
    logic [2:0]  chan;

    logic        rst1, en1, uni1, sdo1;
    logic [7:0]  mask1;
    logic        convst1, sck1, sdi1, valid1, busy1;
    logic [12:0] data1;
    logic [2:0]  chan1;

    unnamed_adc_scanner u_dut (
        .adc_clk(clk), .adc_reset(rst), .enable(en), .chan_mask(mask), .unipolar(uni),
        .CONVST(convst), .SCK(sck), .SDI(sdi), .SDO(sdo),
        .streaming_source_data(data), .streaming_source_channel(chan),
        .streaming_source_valid(valid), .busy(busy)
    );

    unnamed_adc_scanner #(.SCK_DIV(1), .T_CONV(3)) u_dut1 (
        .adc_clk(clk), .adc_reset(rst1), .enable(en1), .chan_mask(mask1), .unipolar(uni1),
        .CONVST(convst1), .SCK(sck1), .SDI(sdi1), .SDO(sdo1),
        .streaming_source_data(data1), .streaming_source_channel(chan1),
        .streaming_source_valid(valid1), .busy(busy1)
    );

    typedef struct {
        int unsigned t;
        logic [12:0] d;
        logic [2:0]  c;
    } ev_t;

    ev_t        vq[$];
    ev_t        vq1[$];
    logic [5:0] wq[$];
    int         checks = 0;
    int         failures = 0;
    int         conv_rises = 0;

    logic [11:0] adc_val [8];
    logic        prev_sck = 1'b0;
    logic        prev_cs = 1'b0;
    int          nrise = 12;
    logic [5:0]  sh_word = 6'd0;
    logic [2:0]  prog_adc = 3'd0;
    logic [2:0]  conv_ch = 3'd0;

    // ADC model and stream monitors.
    always @(negedge clk) begin
        if (valid)  vq.push_back('{t: cyc, d: data, c: chan});
        if (valid1) vq1.push_back('{t: cyc, d: data1, c: chan1});
        if (convst && !prev_cs) begin
            conv_rises++;
            conv_ch = prog_adc;
            nrise = 0;
        end
        if (sck && !prev_sck) begin
            sh_word = {sh_word[4:0], sdi};
            nrise++;
            if (nrise == 6) begin
                wq.push_back(sh_word);
                prog_adc = {sh_word[3], sh_word[2], sh_word[4]};
            end
        end else if (!sck) begin
            sdo = (nrise < 12) ? adc_val[conv_ch][11 - nrise] : 1'b0;
        end
        prev_sck = sck;
        prev_cs = convst;
    end

    function automatic int low_of(input int m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int next_of(input int c, input int m);
        for (int k = 1; k <= 8; k++) if (m[(c + k) % 8]) return (c + k) % 8;
        return c;
    endfunction

    function automatic logic [5:0] word_of(input int c, input logic u);
        logic [2:0] b;
        b = 3'(c);
        return {1'b1, b[0], b[2], b[1], u, 1'b0};
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mask = 8'd0; uni = 1'b0; sdo = 1'b0;
        rst1 = 1'b1; en1 = 1'b0; mask1 = 8'd0; uni1 = 1'b0; sdo1 = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (convst !== 1'b0) begin failures++; $display("FAIL reset_convst got=%0b exp=0", convst); end
        checks++; if (sck !== 1'b0) begin failures++; $display("FAIL reset_sck got=%0b exp=0", sck); end
        checks++; if (sdi !== 1'b0) begin failures++; $display("FAIL reset_sdi got=%0b exp=0", sdi); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
        checks++; if (data !== 13'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", data); end
        checks++; if (chan !== 3'd0) begin failures++; $display("FAIL reset_chan got=%0d exp=0", chan); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy1 got=%0b exp=0", busy1); end
        rst = 1'b0; rst1 = 1'b0;
        @(negedge clk);
    endtask

    // Runs a scan of n valid samples; mask switches m0->m1 at cycle offset change_at.
    task automatic run_scan(input int m0, input int m1, input int change_at, input int n,
                            input logic u, input string name);
        int          t0, budget, prog, m;
        int          exp_tag [16];
        logic        exp_sop [16];
        logic [5:0]  exp_w [16];
        logic [12:0] exp_d;
        vq.delete(); wq.delete();
        mask = 8'(m0); uni = u; en = 1'b1;
        t0 = cyc;
        budget = (n + 3) * 129;
        while (vq.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (cyc == t0 + change_at) mask = 8'(m1);
        end
        en = 1'b0;
        checks++;
        if (vq.size() < n) begin
            failures++; $display("FAIL %s_timeout got=%0d exp=%0d valids", name, vq.size(), n);
        end
        budget = 300;
        while (busy && budget > 0) begin @(negedge clk); budget--; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_idle got=%0b exp=0", name, busy); end
        prog = low_of(m0);
        for (int j = 0; j < n; j++) begin
            m = (change_at > 0 && change_at < 129 * (j + 1)) ? m1 : m0;
            exp_w[j] = word_of(prog, u);
            exp_tag[j] = prog;
            exp_sop[j] = (prog == low_of(m));
            prog = next_of(prog, m);
        end
        for (int j = 0; j < n; j++) begin
            if (j < wq.size()) begin
                checks++;
                if (wq[j] !== exp_w[j]) begin
                    failures++; $display("FAIL %s_sdi_word%0d got=%b exp=%b", name, j, wq[j], exp_w[j]);
                end
            end
            if (j < vq.size()) begin
                exp_d = {exp_sop[j], adc_val[exp_tag[j]]};
                checks++;
                if (vq[j].t !== t0 + 258 + 129 * j) begin
                    failures++; $display("FAIL %s_time%0d got=%0d exp=%0d", name, j, vq[j].t - t0, 258 + 129 * j);
                end
                checks++;
                if (vq[j].c !== 3'(exp_tag[j])) begin
                    failures++; $display("FAIL %s_chan%0d got=%0d exp=%0d", name, j, vq[j].c, exp_tag[j]);
                end
                checks++;
                if (vq[j].d !== exp_d) begin
                    failures++; $display("FAIL %s_data%0d got=%0h exp=%0h", name, j, vq[j].d, exp_d);
                end
            end
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
        adc_val[0] = 12'hABC;
        run_scan(1, 1, 0, 3, 1'b0, "single");
    endtask

    task automatic test_scan();
        int m;
        for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
        run_scan(5, 5, 0, 4, 1'b1, "scan05");
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
            m = $urandom_range(1, 255);
            run_scan(m, m, 0, 5, 1'($urandom), "scan_rand");
        end
    endtask

    task automatic test_mask_change();
        for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
        run_scan(8'h80, 8'h03, 100, 3, 1'b0, "mask_change");
    endtask

    task automatic test_enable_drop();
        int t0, cr0;
        vq.delete();
        mask = 8'($urandom_range(1, 255)); en = 1'b1;
        t0 = cyc;
        while (cyc < t0 + 140) @(negedge clk);
        en = 1'b0;
        cr0 = conv_rises;
        repeat (400) begin
            @(negedge clk);
            if (cyc == t0 + 258) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy_done got=%0b exp=1", busy); end
            end
            if (cyc == t0 + 259) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_busy_after got=%0b exp=0", busy); end
            end
        end
        checks++; if (vq.size() != 1) begin failures++; $display("FAIL drop_count got=%0d exp=1", vq.size()); end
        if (vq.size() > 0) begin
            checks++;
            if (vq[0].t !== t0 + 258) begin
                failures++; $display("FAIL drop_time got=%0d exp=258", vq[0].t - t0);
            end
        end
        checks++; if (conv_rises != cr0) begin failures++; $display("FAIL drop_convst got=%0d exp=%0d", conv_rises, cr0); end
    endtask

    task automatic test_zero_mask();
        int   cr0;
        logic seen_busy;
        vq.delete();
        mask = 8'd0; en = 1'b1;
        cr0 = conv_rises; seen_busy = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        en = 1'b0;
        checks++; if (conv_rises != cr0) begin failures++; $display("FAIL zero_convst got=%0d exp=%0d", conv_rises, cr0); end
        checks++; if (seen_busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%0b exp=0", seen_busy); end
        checks++; if (vq.size() != 0) begin failures++; $display("FAIL zero_valid got=%0d exp=0", vq.size()); end
    endtask

    task automatic test_reset_shift();
        int t0, t1, budget;
        vq1.delete();
        mask1 = 8'h01; en1 = 1'b1;
        t0 = cyc;
        while (cyc < t0 + 38) @(negedge clk);
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL rs_busy_before got=%0b exp=1", busy1); end
        rst1 = 1'b1;
        @(negedge clk);
        checks++; if (sck1 !== 1'b0) begin failures++; $display("FAIL rs_sck got=%0b exp=0", sck1); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rs_busy got=%0b exp=0", busy1); end
        checks++; if (valid1 !== 1'b0) begin failures++; $display("FAIL rs_valid got=%0b exp=0", valid1); end
        checks++; if (data1 !== 13'd0) begin failures++; $display("FAIL rs_data got=%0h exp=0", data1); end
        checks++; if (vq1.size() != 0) begin failures++; $display("FAIL rs_no_valid got=%0d exp=0", vq1.size()); end
        rst1 = 1'b0;
        t1 = cyc;
        budget = 100;
        while (vq1.size() < 1 && budget > 0) begin @(negedge clk); budget--; end
        en1 = 1'b0;
        checks++;
        if (vq1.size() < 1) begin
            failures++; $display("FAIL rs_restart_timeout got=0 exp=1 valids");
        end else begin
            checks++; if (vq1[0].t !== t1 + 56) begin failures++; $display("FAIL rs_restart_time got=%0d exp=56", vq1[0].t - t1); end
            checks++; if (vq1[0].d !== 13'h1FFF) begin failures++; $display("FAIL rs_restart_data got=%0h exp=1fff", vq1[0].d); end
            checks++; if (vq1[0].c !== 3'd0) begin failures++; $display("FAIL rs_restart_chan got=%0d exp=0", vq1[0].c); end
        end
        repeat (40) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_scan();
        test_mask_change();
        test_enable_drop();
        test_zero_mask();
        test_reset_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
